// File: rtl/karat32_seq.sv
// Sequencer for a 32x32 unsigned multiply built from three passes through a
// shared 16x16 multiplier (hi, lo, middle) with Karatsuba reassembly.
module karat32_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_p,
    output logic        mul_req,
    input  logic        mul_gnt,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [31:0] mul_p,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_HI,
        S_MUL_LO,
        S_MUL_MID,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ah_q, ah_d, al_q, al_d, bh_q, bh_d, bl_q, bl_d;
    logic [16:0] sa_q, sa_d, sb_q, sb_d;
    logic [31:0] z2_q, z2_d, z0_q, z0_d;
    logic [63:0] out_p_q, out_p_d;

    // The middle pass only multiplies the low 16 bits of the 17-bit sums, so
    // the dropped carry bits are folded back in before subtracting z2 and z0.
    function automatic logic [63:0] karat_combine(
        input logic [31:0] z2,
        input logic [31:0] z0,
        input logic [31:0] mid,
        input logic [16:0] sa,
        input logic [16:0] sb
    );
        logic [63:0] z1;
        logic [63:0] m;
        z1 = {32'd0, mid};
        if (sa[16]) z1 = z1 + {32'd0, sb[15:0], 16'd0};
        if (sb[16]) z1 = z1 + {32'd0, sa[15:0], 16'd0};
        if (sa[16] & sb[16]) z1 = z1 + 64'h0000_0001_0000_0000;
        m = z1 - {32'd0, z2} - {32'd0, z0};
        return {z2, 32'd0} + (m << 16) + {32'd0, z0};
    endfunction

    always_comb begin
        state_d = state_q;
        ah_d    = ah_q;
        al_d    = al_q;
        bh_d    = bh_q;
        bl_d    = bl_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        z2_d    = z2_q;
        z0_d    = z0_q;
        out_p_d = out_p_q;
        mul_req = 1'b0;
        mul_a   = 16'd0;
        mul_b   = 16'd0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ah_d    = in_a[31:16];
                    al_d    = in_a[15:0];
                    bh_d    = in_b[31:16];
                    bl_d    = in_b[15:0];
                    sa_d    = {1'b0, in_a[31:16]} + {1'b0, in_a[15:0]};
                    sb_d    = {1'b0, in_b[31:16]} + {1'b0, in_b[15:0]};
                    state_d = S_MUL_HI;
                end
            end
            S_MUL_HI: begin
                mul_req = 1'b1;
                mul_a   = ah_q;
                mul_b   = bh_q;
                if (mul_gnt) begin
                    z2_d    = mul_p;
                    state_d = S_MUL_LO;
                end
            end
            S_MUL_LO: begin
                mul_req = 1'b1;
                mul_a   = al_q;
                mul_b   = bl_q;
                if (mul_gnt) begin
                    z0_d    = mul_p;
                    state_d = S_MUL_MID;
                end
            end
            S_MUL_MID: begin
                mul_req = 1'b1;
                mul_a   = sa_q[15:0];
                mul_b   = sb_q[15:0];
                if (mul_gnt) begin
                    out_p_d = karat_combine(z2_q, z0_q, mul_p, sa_q, sb_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ah_q    <= 16'd0;
            al_q    <= 16'd0;
            bh_q    <= 16'd0;
            bl_q    <= 16'd0;
            sa_q    <= 17'd0;
            sb_q    <= 17'd0;
            z2_q    <= 32'd0;
            z0_q    <= 32'd0;
            out_p_q <= 64'd0;
        end else begin
            state_q <= state_d;
            ah_q    <= ah_d;
            al_q    <= al_d;
            bh_q    <= bh_d;
            bl_q    <= bl_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            z2_q    <= z2_d;
            z0_q    <= z0_d;
            out_p_q <= out_p_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_p     = out_p_q;

endmodule

// File: tb/tb_karat32_seq.sv
// Randomized bench for karat32_seq: the bench plays the shared multiplier and
// the arbiter, and checks products against a plain 64-bit multiply.
module tb_karat32_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_p;
    logic        mul_req;
    logic        mul_gnt;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] mul_p;
    logic        busy;

    int n_cmp;
    int n_bad;

    karat32_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .mul_req   (mul_req),
        .mul_gnt   (mul_gnt),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared multiplier: combinational 16x16 product.
    assign mul_p = 32'(mul_a) * 32'(mul_b);

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction, entered and left at a falling edge in IDLE.
    // st_* force that many denied grants at the start of each pass; pct adds
    // random denials; hold keeps out_ready low for that many DONE cycles.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input int st_hi, input int st_lo, input int st_mid,
                         input int pct, input int hold);
        logic [63:0] prod;
        logic [16:0] sa, sb;
        logic [15:0] ea[3];
        logic [15:0] eb[3];
        int          st[3];
        int          grants, stalls, cyc;

        prod  = 64'(a) * 64'(b);
        sa    = 17'(a[31:16]) + 17'(a[15:0]);
        sb    = 17'(b[31:16]) + 17'(b[15:0]);
        ea[0] = a[31:16]; eb[0] = b[31:16];
        ea[1] = a[15:0];  eb[1] = b[15:0];
        ea[2] = sa[15:0]; eb[2] = sb[15:0];
        st[0] = st_hi; st[1] = st_lo; st[2] = st_mid;

        check_val("in_ready_idle", 64'(in_ready), 64'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Noise on the input side that must be ignored while busy.
        in_valid = 1'($urandom_range(1));
        in_a     = $urandom;
        in_b     = $urandom;
        check_val("busy", 64'(busy), 64'd1);
        check_val("in_ready_busy", 64'(in_ready), 64'd0);

        grants = 0;
        stalls = 0;
        cyc    = 1;
        while (!out_valid && cyc < 60) begin
            check_val("mul_req", 64'(mul_req), 64'd1);
            if (grants < 3) begin
                check_val("mul_a", 64'(mul_a), 64'(ea[grants]));
                check_val("mul_b", 64'(mul_b), 64'(eb[grants]));
                if (st[grants] > 0) begin
                    mul_gnt = 1'b0;
                    st[grants]--;
                end else begin
                    mul_gnt = ($urandom_range(99) >= pct);
                end
                if (mul_gnt) grants++;
                else         stalls++;
            end else begin
                check_val("extra_pass", 64'(grants), 64'd3);
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check_val("timeout", 64'(out_valid), 64'd1);
        check_val("grants", 64'(grants), 64'd3);
        check_val("latency", 64'(cyc), 64'(4 + stalls));
        check_val("out_p", out_p, prod);
        check_val("mul_req_done", 64'(mul_req), 64'd0);
        check_val("mul_ab_done", {32'd0, mul_a, mul_b}, 64'd0);
        mul_gnt = 1'($urandom_range(1));

        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom_range(1));
            in_a      = $urandom;
            in_b      = $urandom;
            @(posedge clk);
            @(negedge clk);
            check_val("hold_valid", 64'(out_valid), 64'd1);
            check_val("hold_out_p", out_p, prod);
            check_val("hold_in_ready", 64'(in_ready), 64'd0);
        end

        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'($urandom_range(1));
        in_valid  = 1'b0;
        check_val("released_valid", 64'(out_valid), 64'd0);
        check_val("released_ready", 64'(in_ready), 64'd1);
        check_val("released_busy", 64'(busy), 64'd0);
        check_val("kept_out_p", out_p, prod);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        out_ready = 1'b0;
        mul_gnt   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_mul_req", 64'(mul_req), 64'd0);
        check_val("rst_out_p", out_p, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'h0000FFFF, 32'h00010001, 0, 0, 0, 0, 0);
        check_val("basic", out_p, 64'h00000000FFFFFFFF);
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        check_val("both_carry", out_p, 64'hFFFFFFFE00000001);
        do_op(32'h80000000, 32'h00000002, 0, 0, 0, 0, 0);
        check_val("mixed_1", out_p, 64'h0000000100000000);
        do_op(32'h00010000, 32'h00010000, 0, 0, 0, 0, 0);
        check_val("mixed_2", out_p, 64'h0000000100000000);

        // Two denials in the high pass and one in the middle pass: latency 7.
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2, 0, 1, 0, 0);

        // Back-pressure followed by an immediate back-to-back transaction.
        do_op($urandom, $urandom, 0, 0, 0, 0, 3);
        do_op($urandom, $urandom, 0, 0, 0, 0, 0);

        // Operand halves near the carry boundaries, then fully random traffic.
        do_op(32'hFFFF0001, 32'h0001FFFF, 0, 1, 0, 0, 1);
        do_op(32'h80008000, 32'h80008000, 1, 1, 1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            do_op($urandom, $urandom, 0, 0, 0, 30, int'($urandom_range(3)));
        end

        // Reset in the middle of the low pass.
        in_a     = 32'h12345678;
        in_b     = 32'h9ABCDEF0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        mul_gnt  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("pre_rst_mul_a", 64'(mul_a), 64'h5678);
        rst_n = 1'b0;
        #1;
        check_val("arst_in_ready", 64'(in_ready), 64'd1);
        check_val("arst_out_valid", 64'(out_valid), 64'd0);
        check_val("arst_busy", 64'(busy), 64'd0);
        check_val("arst_mul_req", 64'(mul_req), 64'd0);
        check_val("arst_mul_ab", {32'd0, mul_a, mul_b}, 64'd0);
        check_val("arst_out_p", out_p, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(32'd3, 32'd5, 0, 0, 0, 0, 0);
        check_val("after_rst", out_p, 64'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
